// File: rtl/regfile_mp.sv
// Multi-port integer register file: N_RD combinational reads, two prioritised writes,
// optional write-to-read bypass, per-entry pending scoreboard and a post-reset clear engine.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_CLEAR | zeroing one entry per edge from clr_ptr; file not usable
// ST_RUN   | normal operation until the next reset
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int N_RD   = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_wa_en,
  input  logic [AW-1:0]          i_wa_addr,
  input  logic [DATA_W-1:0]      i_wa_data,
  input  logic                   i_wb_en,
  input  logic [AW-1:0]          i_wb_addr,
  input  logic [DATA_W-1:0]      i_wb_data,
  input  logic [N_RD*AW-1:0]     i_raddr,
  output logic [N_RD*DATA_W-1:0] o_rdata,
  output logic [N_RD-1:0]        o_rpend,
  input  logic                   i_alloc_en,
  input  logic [AW-1:0]          i_alloc_addr,
  input  logic                   i_flush,
  output logic                   o_ready
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
  logic              ready_q, ready_d;
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic wa_ok, wb_ok, alloc_ok;

  // Entry 0 is hardwired zero; addresses past DEPTH (non power-of-two files) do not exist.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && (int'(a) < DEPTH);
  endfunction

  assign wb_ok    = ready_q && i_wb_en && addr_ok(i_wb_addr);
  assign wa_ok    = ready_q && i_wa_en && addr_ok(i_wa_addr) && !(wb_ok && (i_wb_addr == i_wa_addr));
  assign alloc_ok = ready_q && i_alloc_en && addr_ok(i_alloc_addr);
  assign o_ready  = ready_q;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    ready_d   = ready_q;
    case (state_q)
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + AW'(1);
        if (clr_ptr_q == AW'(DEPTH - 1)) begin
          state_d   = ST_RUN;
          ready_d   = 1'b1;
          clr_ptr_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Alloc after write-clear so a same-cycle new producer keeps the bit set; flush beats both.
  always_comb begin
    pend_d = pend_q;
    if (ready_q) begin
      if (wa_ok) pend_d[i_wa_addr] = 1'b0;
      if (wb_ok) pend_d[i_wb_addr] = 1'b0;
      if (alloc_ok) pend_d[i_alloc_addr] = 1'b1;
      if (i_flush) pend_d = '0;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
      pend_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
      pend_q    <= pend_d;
    end
  end

  // Storage is not reset; the clear engine zeroes it one entry per edge instead.
  always_ff @(posedge i_clk) begin
    if (i_rstn) begin
      if (state_q == ST_CLEAR) begin
        mem_q[clr_ptr_q] <= '0;
      end else begin
        if (wa_ok) mem_q[i_wa_addr] <= i_wa_data;
        if (wb_ok) mem_q[i_wb_addr] <= i_wb_data;
      end
    end
  end

  always_comb begin
    logic [AW-1:0] ra;
    ra      = '0;
    o_rdata = '0;
    o_rpend = '0;
    for (int k = 0; k < N_RD; k++) begin
      ra = i_raddr[k*AW +: AW];
      if (ready_q && addr_ok(ra)) begin
        if ((BYPASS != 0) && wb_ok && (i_wb_addr == ra)) begin
          o_rdata[k*DATA_W +: DATA_W] = i_wb_data;
        end else if ((BYPASS != 0) && wa_ok && (i_wa_addr == ra)) begin
          o_rdata[k*DATA_W +: DATA_W] = i_wa_data;
        end else begin
          o_rdata[k*DATA_W +: DATA_W] = mem_q[ra];
          o_rpend[k]                  = pend_q[ra];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a bypassing 32-entry file, a non-bypassing twin and a
// 24-entry file share one stimulus stream so each scenario is checked against all three.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wa_en, wb_en, alloc_en, flush;
  logic [4:0]  wa_addr, wb_addr, alloc_addr;
  logic [31:0] wa_data, wb_data;
  logic [9:0]  raddr;
  logic [63:0] rd_a, rd_b, rd_c;
  logic [1:0]  rp_a, rp_b, rp_c;
  logic        rdy_a, rdy_b, rdy_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .DEPTH(32), .N_RD(2), .BYPASS(1)) u_byp (
    .i_clk(clk), .i_rstn(rstn),
    .i_wa_en(wa_en), .i_wa_addr(wa_addr), .i_wa_data(wa_data),
    .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .i_raddr(raddr), .o_rdata(rd_a), .o_rpend(rp_a),
    .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr), .i_flush(flush),
    .o_ready(rdy_a)
  );

  regfile_mp #(.DATA_W(32), .DEPTH(32), .N_RD(2), .BYPASS(0)) u_nobyp (
    .i_clk(clk), .i_rstn(rstn),
    .i_wa_en(wa_en), .i_wa_addr(wa_addr), .i_wa_data(wa_data),
    .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .i_raddr(raddr), .o_rdata(rd_b), .o_rpend(rp_b),
    .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr), .i_flush(flush),
    .o_ready(rdy_b)
  );

  regfile_mp #(.DATA_W(32), .DEPTH(24), .N_RD(2), .BYPASS(1)) u_d24 (
    .i_clk(clk), .i_rstn(rstn),
    .i_wa_en(wa_en), .i_wa_addr(wa_addr), .i_wa_data(wa_data),
    .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .i_raddr(raddr), .o_rdata(rd_c), .o_rpend(rp_c),
    .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr), .i_flush(flush),
    .o_ready(rdy_c)
  );

  task automatic idle();
    wa_en = 1'b0; wb_en = 1'b0; alloc_en = 1'b0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick(); tick();
    n_checks++;
    if (rdy_a !== 1'b0 || rdy_c !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b/%b exp 0/0", rdy_a, rdy_c);
    end
    n_checks++;
    if (rd_a !== 64'h0 || rp_a !== 2'b00) begin
      n_fail++; $display("FAIL reset_outputs: rdata %h rpend %b exp 0/0", rd_a, rp_a);
    end
    rstn = 1'b1;
    repeat (32) tick();
    n_checks++;
    if (rdy_a !== 1'b1 || rdy_b !== 1'b1 || rdy_c !== 1'b1) begin
      n_fail++; $display("FAIL bringup_ready: got %b%b%b exp 111", rdy_a, rdy_b, rdy_c);
    end
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEADBEEF;
    tick(); idle();
    raddr = {5'd0, 5'd5};
    #1;
    n_checks++;
    if (rd_b[31:0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL preload: got %h exp deadbeef", rd_b[31:0]);
    end
    // Re-clear while hammering entry 5 with writes/allocs that must be ignored.
    rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'h12345678;
    alloc_en = 1'b1; alloc_addr = 5'd5;
    for (int e = 1; e <= 32; e++) begin
      tick();
      if (e == 20) idle();
      n_checks++;
      if (rdy_a !== (e >= 32) || rdy_b !== (e >= 32) || rdy_c !== (e >= 24)) begin
        n_fail++; $display("FAIL clear_ready edge %0d: got %b%b%b", e, rdy_a, rdy_b, rdy_c);
      end
      if (e < 20) begin
        n_checks++;
        if (rd_a !== 64'h0 || rp_a !== 2'b00 || rd_c !== 64'h0) begin
          n_fail++; $display("FAIL clear_gated edge %0d: rdata %h pend %b exp 0", e, rd_a, rp_a);
        end
      end
    end
    #1;
    n_checks++;
    if (rd_a[31:0] !== 32'h0 || rd_b[31:0] !== 32'h0 || rd_c[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL cleared_entry5: got %h %h %h exp 0", rd_a[31:0], rd_b[31:0], rd_c[31:0]);
    end
    n_checks++;
    if (rp_a !== 2'b00 || rp_c !== 2'b00) begin
      n_fail++; $display("FAIL cleared_pend5: got %b %b exp 00", rp_a, rp_c);
    end
  endtask

  task automatic test_priority();
    wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h11111111;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h22222222;
    raddr = {5'd0, 5'd7};
    #1;
    n_checks++;
    if (rd_a[31:0] !== 32'h22222222 || rd_b[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL prio_comb: got %h/%h exp 22222222/0", rd_a[31:0], rd_b[31:0]);
    end
    tick(); idle(); #1;
    n_checks++;
    if (rd_a[31:0] !== 32'h22222222 || rd_b[31:0] !== 32'h22222222) begin
      n_fail++; $display("FAIL prio_commit: got %h/%h exp 22222222", rd_a[31:0], rd_b[31:0]);
    end
    wa_en = 1'b1; wa_addr = 5'd1; wa_data = 32'hAAAAAAAA;
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'hBBBBBBBB;
    tick(); idle();
    raddr = {5'd2, 5'd1};
    #1;
    n_checks++;
    if (rd_b !== 64'hBBBBBBBB_AAAAAAAA) begin
      n_fail++; $display("FAIL dual_write: got %h exp bbbbbbbbaaaaaaaa", rd_b);
    end
    wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFFFFFF;
    raddr = {5'd0, 5'd0};
    #1;
    n_checks++;
    if (rd_a[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL zero_bypass: got %h exp 0", rd_a[31:0]);
    end
    tick(); idle(); #1;
    n_checks++;
    if (rd_a[31:0] !== 32'h0 || rd_b[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL zero_commit: got %h/%h exp 0", rd_a[31:0], rd_b[31:0]);
    end
  endtask

  task automatic test_bypass();
    wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'hA5A5A5A5;
    raddr = {5'd0, 5'd3};
    #1;
    n_checks++;
    if (rd_a[31:0] !== 32'hA5A5A5A5 || rd_c[31:0] !== 32'hA5A5A5A5 || rd_b[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL bypass_same_cycle: got %h %h %h exp a5a5a5a5 a5a5a5a5 0",
                         rd_a[31:0], rd_c[31:0], rd_b[31:0]);
    end
    tick(); idle(); #1;
    n_checks++;
    if (rd_b[31:0] !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL nobypass_next: got %h exp a5a5a5a5", rd_b[31:0]);
    end
  endtask

  task automatic test_scoreboard();
    alloc_en = 1'b1; alloc_addr = 5'd9;
    tick(); idle();
    raddr = {5'd9, 5'd0};
    #1;
    n_checks++;
    if (rp_a !== 2'b10 || rp_b !== 2'b10) begin
      n_fail++; $display("FAIL alloc_pend: got %b/%b exp 10", rp_a, rp_b);
    end
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h00000099;
    #1;
    n_checks++;
    if (rp_a !== 2'b00 || rp_b !== 2'b10 || rd_a[63:32] !== 32'h99) begin
      n_fail++; $display("FAIL fwd_pend: got %b/%b data %h exp 00/10 99", rp_a, rp_b, rd_a[63:32]);
    end
    tick(); idle(); #1;
    n_checks++;
    if (rp_a !== 2'b00 || rp_b !== 2'b00) begin
      n_fail++; $display("FAIL write_clears: got %b/%b exp 00", rp_a, rp_b);
    end
    alloc_en = 1'b1; alloc_addr = 5'd9;
    wa_en = 1'b1; wa_addr = 5'd9; wa_data = 32'h00000098;
    tick(); idle(); #1;
    n_checks++;
    if (rp_a !== 2'b10 || rp_b !== 2'b10 || rd_b[63:32] !== 32'h98) begin
      n_fail++; $display("FAIL alloc_beats_write: got %b/%b data %h exp 10/10 98", rp_a, rp_b, rd_b[63:32]);
    end
    alloc_en = 1'b1; alloc_addr = 5'd0;
    tick(); idle(); #1;
    n_checks++;
    if (rp_a !== 2'b10 || rp_b !== 2'b10) begin
      n_fail++; $display("FAIL alloc_zero: got %b/%b exp 10", rp_a, rp_b);
    end
  endtask

  task automatic test_flush();
    alloc_en = 1'b1;
    alloc_addr = 5'd4; tick();
    alloc_addr = 5'd6; tick();
    alloc_addr = 5'd8; tick();
    idle();
    raddr = {5'd8, 5'd4};
    #1;
    n_checks++;
    if (rp_a !== 2'b11) begin
      n_fail++; $display("FAIL pre_flush: got %b exp 11", rp_a);
    end
    flush = 1'b1; alloc_en = 1'b1; alloc_addr = 5'd10;
    wa_en = 1'b1; wa_addr = 5'd11; wa_data = 32'h55555555;
    tick(); idle();
    raddr = {5'd10, 5'd6};
    #1;
    n_checks++;
    if (rp_a !== 2'b00 || rp_b !== 2'b00) begin
      n_fail++; $display("FAIL flush_beats_alloc: got %b/%b exp 00", rp_a, rp_b);
    end
    raddr = {5'd8, 5'd4};
    #1;
    n_checks++;
    if (rp_a !== 2'b00) begin
      n_fail++; $display("FAIL flush_clears: got %b exp 00", rp_a);
    end
    raddr = {5'd9, 5'd11};
    #1;
    n_checks++;
    if (rd_a[31:0] !== 32'h55555555 || rp_a !== 2'b00) begin
      n_fail++; $display("FAIL flush_write: got %h pend %b exp 55555555 00", rd_a[31:0], rp_a);
    end
  endtask

  task automatic test_mid_reset();
    wa_en = 1'b1; wa_addr = 5'd20; wa_data = 32'h20202020;
    tick(); idle();
    rstn = 1'b0; tick(); rstn = 1'b1;
    repeat (12) tick();
    n_checks++;
    if (rdy_a !== 1'b0 || rdy_c !== 1'b0) begin
      n_fail++; $display("FAIL mid_clear_ready: got %b/%b exp 0/0", rdy_a, rdy_c);
    end
    rstn = 1'b0; tick(); rstn = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      tick();
      n_checks++;
      if (rdy_a !== (e >= 32) || rdy_c !== (e >= 24)) begin
        n_fail++; $display("FAIL restart_ready edge %0d: got %b/%b", e, rdy_a, rdy_c);
      end
    end
    raddr = {5'd11, 5'd20};
    #1;
    n_checks++;
    if (rd_a !== 64'h0 || rd_b !== 64'h0) begin
      n_fail++; $display("FAIL restart_cleared: got %h/%h exp 0", rd_a, rd_b);
    end
  endtask

  task automatic test_out_of_range();
    wa_en = 1'b1; wa_addr = 5'd30; wa_data = 32'h77777777;
    alloc_en = 1'b1; alloc_addr = 5'd30;
    raddr = {5'd6, 5'd30};
    #1;
    n_checks++;
    if (rd_c[31:0] !== 32'h0 || rd_a[31:0] !== 32'h77777777) begin
      n_fail++; $display("FAIL oor_bypass: got %h/%h exp 0/77777777", rd_c[31:0], rd_a[31:0]);
    end
    tick(); idle(); #1;
    n_checks++;
    if (rd_c !== 64'h0 || rp_c !== 2'b00) begin
      n_fail++; $display("FAIL oor_d24: got %h pend %b exp 0 00", rd_c, rp_c);
    end
    n_checks++;
    if (rd_a[31:0] !== 32'h77777777 || rp_a !== 2'b01) begin
      n_fail++; $display("FAIL inrange_d32: got %h pend %b exp 77777777 01", rd_a[31:0], rp_a);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    idle();
    wa_addr = '0; wb_addr = '0; alloc_addr = '0;
    wa_data = '0; wb_data = '0; raddr = '0;
    test_reset();
    test_priority();
    test_bypass();
    test_scoreboard();
    test_flush();
    test_mid_reset();
    test_out_of_range();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
